// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared WS2812 state encoding, word size and ns-to-cycle conversion
package ws2812_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_e;

    localparam int BITS_PER_PIXEL = 24;

    // Whole clock cycles contained in a duration, rounded down.
    function automatic int ns_to_cyc(input longint ns, input longint f_clk);
        longint cyc;
        cyc = (ns * f_clk) / longint'(1_000_000_000);
        return int'(cyc);
    endfunction

endpackage

// File: rtl/ws2812_sync.sv
// rtl/ws2812_sync.sv - two-flop synchronizer for the asynchronous data line
// Ports: clk, rst_n (async, active low, clears both flops), d (async input), q (synchronized output)
module ws2812_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 NRZ receiver: pulse-width bit decode, 24-bit GRB words, latch-gap framing
// Ports: clk, rst_n (async, active low), din (raw line),
//        pixel_data/pixel_valid/pixel_index (decoded words),
//        frame_done/frame_pixels (clean latch gap), err (protocol error pulse),
//        synced (locked to frame structure)
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int F_CLK         = 50_000_000,
    parameter int T_THRESH_NS   = 600,
    parameter int T_MIN_HIGH_NS = 100,
    parameter int T_MAX_HIGH_NS = 2000,
    parameter int T_RESET_NS    = 50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [15:0] pixel_index,
    output logic        frame_done,
    output logic [15:0] frame_pixels,
    output logic        err,
    output logic        synced
);

    localparam int THRESH_CYC   = ns_to_cyc(longint'(T_THRESH_NS), longint'(F_CLK));
    localparam int MIN_HIGH_CYC = ns_to_cyc(longint'(T_MIN_HIGH_NS), longint'(F_CLK));
    localparam int MAX_HIGH_CYC = ns_to_cyc(longint'(T_MAX_HIGH_NS), longint'(F_CLK));
    localparam int RESET_CYC    = ns_to_cyc(longint'(T_RESET_NS), longint'(F_CLK));
    localparam int CW           = $clog2(RESET_CYC + 1);

    localparam logic [CW-1:0] THRESH_C   = CW'(THRESH_CYC);
    localparam logic [CW-1:0] MIN_HIGH_C = CW'(MIN_HIGH_CYC);
    localparam logic [CW-1:0] MAX_HIGH_C = CW'(MAX_HIGH_CYC);
    localparam logic [CW-1:0] RESET_C    = CW'(RESET_CYC);
    localparam logic [4:0]    LAST_BIT   = 5'(BITS_PER_PIXEL - 1);

    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    logic din_s;

    ws2812_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (din_s)
    );

    state_e        state_q, state_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]   pix_cnt_q, pix_cnt_d;
    logic [23:0]   shift_q, shift_d;
    logic [23:0]   pixel_data_q, pixel_data_d;
    logic [15:0]   pixel_index_q, pixel_index_d;
    logic [15:0]   frame_pixels_q, frame_pixels_d;
    logic          pixel_valid_q, pixel_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          err_q, err_d;

    logic          new_bit;
    logic [23:0]   word;
    logic [CW-1:0] hcnt_inc;
    logic [CW-1:0] lcnt_inc;

    always_comb begin
        state_d        = state_q;
        hcnt_d         = hcnt_q;
        lcnt_d         = lcnt_q;
        bit_cnt_d      = bit_cnt_q;
        pix_cnt_d      = pix_cnt_q;
        shift_d        = shift_q;
        pixel_data_d   = pixel_data_q;
        pixel_index_d  = pixel_index_q;
        frame_pixels_d = frame_pixels_q;
        pixel_valid_d  = 1'b0;
        frame_done_d   = 1'b0;
        err_d          = 1'b0;

        // hcnt holds the full high length on the first low cycle, so the
        // bit decision is made on the registered count.
        new_bit  = (hcnt_q >= THRESH_C);
        word     = {shift_q[22:0], new_bit};
        hcnt_inc = cnt_inc(hcnt_q);
        lcnt_inc = cnt_inc(lcnt_q);

        case (state_q)
            SYNC: begin
                // Any partial frame is dropped while hunting for a gap.
                bit_cnt_d = '0;
                pix_cnt_d = '0;
                hcnt_d    = '0;
                if (din_s) begin
                    lcnt_d = '0;
                end else begin
                    lcnt_d = lcnt_inc;
                    if (lcnt_inc >= RESET_C) begin
                        state_d = IDLE;
                    end
                end
            end

            IDLE: begin
                bit_cnt_d = '0;
                pix_cnt_d = '0;
                shift_d   = '0;
                if (din_s) begin
                    hcnt_d  = CW'(1);
                    state_d = HIGH;
                end
            end

            HIGH: begin
                if (din_s) begin
                    hcnt_d = hcnt_inc;
                    if (hcnt_inc >= MAX_HIGH_C) begin
                        err_d   = 1'b1;
                        lcnt_d  = '0;
                        state_d = SYNC;
                    end
                end else if (hcnt_q < MIN_HIGH_C) begin
                    err_d   = 1'b1;
                    lcnt_d  = '0;
                    state_d = SYNC;
                end else begin
                    shift_d = word;
                    lcnt_d  = CW'(1);
                    state_d = LOW;
                    if (bit_cnt_q == LAST_BIT) begin
                        pixel_data_d  = word;
                        pixel_valid_d = 1'b1;
                        pixel_index_d = pix_cnt_q;
                        pix_cnt_d     = (pix_cnt_q == 16'hFFFF) ? pix_cnt_q : pix_cnt_q + 16'd1;
                        bit_cnt_d     = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end

            LOW: begin
                if (din_s) begin
                    hcnt_d  = CW'(1);
                    state_d = HIGH;
                end else begin
                    lcnt_d = lcnt_inc;
                    if (lcnt_inc >= RESET_C) begin
                        state_d = IDLE;
                        if (bit_cnt_q != '0) begin
                            err_d = 1'b1;
                        end else if (pix_cnt_q != '0) begin
                            frame_done_d   = 1'b1;
                            frame_pixels_d = pix_cnt_q;
                        end
                    end
                end
            end

            default: begin
                state_d = SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= SYNC;
            hcnt_q         <= '0;
            lcnt_q         <= '0;
            bit_cnt_q      <= '0;
            pix_cnt_q      <= '0;
            shift_q        <= '0;
            pixel_data_q   <= '0;
            pixel_index_q  <= '0;
            frame_pixels_q <= '0;
            pixel_valid_q  <= 1'b0;
            frame_done_q   <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            hcnt_q         <= hcnt_d;
            lcnt_q         <= lcnt_d;
            bit_cnt_q      <= bit_cnt_d;
            pix_cnt_q      <= pix_cnt_d;
            shift_q        <= shift_d;
            pixel_data_q   <= pixel_data_d;
            pixel_index_q  <= pixel_index_d;
            frame_pixels_q <= frame_pixels_d;
            pixel_valid_q  <= pixel_valid_d;
            frame_done_q   <= frame_done_d;
            err_q          <= err_d;
        end
    end

    assign pixel_data   = pixel_data_q;
    assign pixel_valid  = pixel_valid_q;
    assign pixel_index  = pixel_index_q;
    assign frame_done   = frame_done_q;
    assign frame_pixels = frame_pixels_q;
    assign err          = err_q;
    assign synced       = (state_q != SYNC);

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Receiver/decoder for the single-wire WS2812 NRZ stream that the board's WS2812 transmitter drives out on J3_10.
- Measures each high pulse to classify it as a 0 or 1 bit. Assembles 24-bit GRB pixel words and detects the ≥50 µs low latch gap as end of frame.
- Used for on-board loopback self-test of the transmitter and as the input stage of a daisy-chain repeater.

Parameters:
- F_CLK, 50_000_000: system clock frequency in Hz.
- T_THRESH_NS, 600: high time at or above this decodes as 1; below decodes as 0.
- T_MIN_HIGH_NS, 100: high pulses shorter than this are glitches (error).
- T_MAX_HIGH_NS, 2000: high pulses reaching this length are errors.
- T_RESET_NS, 50_000: continuous low time that marks the latch/reset gap.
- Derived cycle counts (integer division, rounded down): THRESH_CYC=30, MIN_HIGH_CYC=5, MAX_HIGH_CYC=100, RESET_CYC=2500 at defaults.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- din, input, 1: raw WS2812 data line, asynchronous to clk.
- pixel_data, output, 24: last completed word, MSB first as received (G[7:0], R[7:0], B[7:0]).
- pixel_valid, output, 1: one-cycle pulse; pixel_data is new.
- pixel_index, output, 16: index within the frame of the word flagged by pixel_valid.
- frame_done, output, 1: one-cycle pulse at a clean latch gap.
- frame_pixels, output, 16: pixel count of the last clean frame; updated with frame_done.
- err, output, 1: one-cycle pulse on any protocol error.
- synced, output, 1: high while the receiver is locked to the frame structure (any state except SYNC).

Behaviour:
- Reset: all outputs 0; state SYNC; bit, pixel and width counters 0.
- Input path: din passes through a 2-FF synchronizer to din_s; the FSM uses din_s only.
- Outputs are registered. pixel_valid, frame_done and err rise on the clk edge after the FSM sees the qualifying din_s value. From a din pin edge to the output pulse is 3 clk edges.
- Counter width is $clog2(RESET_CYC+1). Counters saturate and never wrap.
- hcnt = number of consecutive cycles din_s is high. lcnt = number of consecutive cycles din_s is low.
- SYNC:
  - din_s low: lcnt counts up; when lcnt reaches RESET_CYC, go to IDLE.
  - din_s high: clear lcnt.
  - A line stuck high stays in SYNC indefinitely.
- IDLE:
  - bit_cnt=0 and pix_cnt=0.
  - din_s high → HIGH with hcnt=1.
- HIGH:
  - din_s high: hcnt+1. If hcnt reaches MAX_HIGH_CYC → err, go to SYNC.
  - din_s low with hcnt<MIN_HIGH_CYC → err, go to SYNC.
  - din_s low otherwise: shift in bit (hcnt≥THRESH_CYC) at the LSB, go to LOW with lcnt=1.
  - If this was bit 23: pixel_data ← assembled word, pixel_valid=1, pixel_index=pix_cnt, pix_cnt+1 (saturates at 0xFFFF), bit_cnt←0. Otherwise bit_cnt+1.
- LOW:
  - din_s high → HIGH with hcnt=1. There is no minimum low time.
  - lcnt reaches RESET_CYC with bit_cnt=0 and pix_cnt>0: frame_done=1, frame_pixels←pix_cnt, go to IDLE.
  - lcnt reaches RESET_CYC with bit_cnt≠0: err=1, discard the partial word, go to IDLE. frame_done stays 0 and frame_pixels is unchanged.
- Error handling: the SYNC path re-requires a full RESET_CYC low gap, and any pixels in the aborted frame are discarded.
- No back-pressure: the consumer must take pixel_data on the pixel_valid cycle. pixel_data holds its value until the next word.
- rst_n asserted mid-word: immediate return to reset values. After release the block needs a full gap before decoding.

Decomposition:
- Package ws2812_pkg holds:
  - state enum {SYNC, IDLE, HIGH, LOW};
  - BITS_PER_PIXEL=24;
  - function ns_to_cyc(ns, f_clk), shared with the transmitter timing constants.
- One sub-module, ws2812_sync: 2-FF synchronizer with rst_n clearing both flops to 0.
- FSM, counters and shift register live in ws2812_rx.

Test Plan:
1. After rst_n release, din low for 2500 clk, then 24 bits of 0xFF0000 (1 = 40 clk high/22 low, 0 = 20 high/42 low) → synced=1, one pixel_valid, pixel_data=0xFF0000, pixel_index=0.
2. Three pixels 0x123456, 0xABCDEF, 0x000001, then 2500 clk low → three pixel_valid pulses with indices 0/1/2, then frame_done with frame_pixels=3, err never asserted.
3. Threshold sweep within one word: high of 29 clk decodes as 0, 30 clk decodes as 1. Word of alternating 29/30-clk highs → 0x555555.
4. 3-clk glitch mid-word → err pulse, synced=0, no pixel_valid; subsequent bits ignored until 2500 clk low, then decoding resumes at index 0.
5. 12 bits then 2500 clk low → err pulse, no pixel_valid, no frame_done, frame_pixels retains its prior value; high held for 100 clk → err.
6. rst_n low after bit 10 → all outputs 0 immediately; din stuck high after release → synced stays 0 for 10000 clk.
